// File: rtl/serial_adder_ctrl_pkg.sv
// Shared state encodings and digit width for the serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int DIG_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_adder_slice2.sv
// Combinational 2-bit ripple adder slice built from two full adders; holds no state.
module adder_slice2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);

    logic c1;

    always_comb begin
        s[0] = a[0] ^ b[0] ^ ci;
        c1   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
        s[1] = a[1] ^ b[1] ^ c1;
        co   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial adder controller: adds two WIDTH-bit operands two bits per clock through
// one adder_slice2, carrying between digits in a register.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NDIG  = WIDTH / DIG_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [DIG_W-1:0]   s;
    logic               c2;

    adder_slice2 u_slice (
        .a  (a_sh[DIG_W-1:0]),
        .b  (b_sh[DIG_W-1:0]),
        .ci (carry),
        .s  (s),
        .co (c2)
    );

    // New digit enters at the top so the first (LSB) digit ends up in sum[1:0].
    generate
        if (WIDTH == DIG_W) begin : g_sum_single
            assign sum_nxt = s;
        end else begin : g_sum_shift
            assign sum_nxt = {s, sum[WIDTH-1:DIG_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort wins even over the final digit; partial sum stays frozen.
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        sum   <= sum_nxt;
                        a_sh  <= a_sh >> DIG_W;
                        b_sh  <= b_sh >> DIG_W;
                        carry <= c2;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(NDIG - 1)) begin
                            cout  <= c2;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 and WIDTH=2 instances, directed vectors.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start2 = 1'b0;
    logic       abort2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int checks = 0;
    int failures = 0;

    logic [8:0] expq[$];
    logic [2:0] expq2[$];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .abort (abort2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=%0h required=none", {cout, sum});
            end else begin
                checkOutput("sb_result8", {23'd0, cout, sum}, {23'd0, expq.pop_front()});
            end
        end
        if (rst_n && done2) begin
            if (expq2.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done2 actual=%0h required=none", {cout2, sum2});
            end else begin
                checkOutput("sb_result2", {29'd0, cout2, sum2}, {29'd0, expq2.pop_front()});
            end
        end
    end

    // Drives one request; leaves us at the negedge right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                                 input logic [7:0] es, input logic ec, input bit expect_done,
                                 input bit hold_start);
        @(negedge clk);
        a = av;
        b = bv;
        cin = ci;
        start = 1'b1;
        if (expect_done) expq.push_back({ec, es});
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic waitDone(input int exp_k);
        int k;
        k = 21;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
        end
        checkOutput("done_latency", k, exp_k);
    endtask

    initial begin
        #12;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_sum", {24'd0, sum}, 32'd0);
        checkOutput("reset_cout", {31'd0, cout}, 32'd0);
        checkOutput("reset_busy2", {31'd0, busy2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, 4-digit latency.
        applyStimulus(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        waitDone(4);

        // Full carry ripple from digit 0 to cout.
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        waitDone(4);
        applyStimulus(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        waitDone(4);

        // Inputs changed mid-run are ignored; start held through DONE is taken at the next IDLE edge.
        applyStimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        a = 8'h00;
        b = 8'h00;
        start = 1'b1;
        waitDone(3);
        a = 8'h11;
        b = 8'h22;
        expq.push_back({1'b0, 8'h33});
        @(negedge clk);
        checkOutput("idle_gap_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
        waitDone(4);

        // Abort at E2: back to IDLE, no done pulse.
        applyStimulus(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 6; i++) @(negedge clk);
        checkOutput("abort_queue", expq.size(), 32'd0);
        applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, 1'b0);
        waitDone(4);

        // Leave cout=1 behind, then reset asynchronously mid-run.
        applyStimulus(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        waitDone(4);
        applyStimulus(8'h55, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_rst_done", {31'd0, done}, 32'd0);
        checkOutput("async_rst_sum", {24'd0, sum}, 32'd0);
        checkOutput("async_rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        waitDone(4);

        // WIDTH=2 instance: single-digit add finishes after one edge.
        @(negedge clk);
        a2 = 2'b11;
        b2 = 2'b11;
        cin2 = 1'b1;
        start2 = 1'b1;
        expq2.push_back({1'b1, 2'b11});
        @(negedge clk);
        start2 = 1'b0;
        checkOutput("w2_busy", {31'd0, busy2}, 32'd1);
        checkOutput("w2_done_early", {31'd0, done2}, 32'd0);
        @(negedge clk);
        checkOutput("w2_done", {31'd0, done2}, 32'd1);
        @(negedge clk);
        checkOutput("w2_idle", {31'd0, busy2}, 32'd0);

        @(negedge clk);
        checkOutput("sb_drain8", expq.size(), 32'd0);
        checkOutput("sb_drain2", expq2.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
